// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw pin in, conditioned level/strobes/count out.
// Signal prefixes are from the conditioner's point of view (i_ into it, o_ out of it).
interface button_conditioner_if;
    logic       i_btn_raw;
    logic       o_level;
    logic       o_press;
    logic       o_release;
    logic [7:0] o_press_count;
    logic       o_long_press;
    logic       o_held;

    // Stimulus side: drives the pin, observes the conditioned outputs.
    modport master (
        output i_btn_raw,
        input  o_level,
        input  o_press,
        input  o_release,
        input  o_press_count,
        input  o_long_press,
        input  o_held
    );

    // Conditioner side.
    modport slave (
        input  i_btn_raw,
        output o_level,
        output o_press,
        output o_release,
        output o_press_count,
        output o_long_press,
        output o_held
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, polarity fix, debounce, press/release
// strobes, wrapping 8-bit press counter and an optional long-press detector.
// Optional feature macro: BUTTON_LONGPRESS_EN (builds the IDLE/DOWN/HELD FSM and hold
// counter; when undefined long_press and held are tied low and LONG_CYCLES is ignored).
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned LONG_CYCLES     = 25000000,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input logic                 i_clk,
    input logic                 i_rst,
    button_conditioner_if.slave bus
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            r_s1;
    logic            r_s2;
    logic            w_sample;
    logic [CntW-1:0] r_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic [7:0]      r_press_count;
    logic            w_accept;
    logic            w_rise;
    logic            w_fall;

    // Pressed = 1 regardless of pin polarity; reset value keeps sample at 0.
    assign w_sample = r_s2 ^ ACTIVE_LOW;
    // A change is accepted on the cycle the disagreement count reaches its last value.
    assign w_accept = (w_sample != r_level) && (r_cnt == CntLast);
    assign w_rise   = w_accept && w_sample;
    assign w_fall   = w_accept && !w_sample;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= ACTIVE_LOW;
            r_s2 <= ACTIVE_LOW;
        end else begin
            r_s1 <= bus.i_btn_raw;
            r_s2 <= r_s1;
        end
    end

    // Debounce counter, debounced level, edge strobes and press counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt         <= '0;
            r_level       <= 1'b0;
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_press_count <= 8'd0;
        end else begin
            r_press   <= w_rise;
            r_release <= w_fall;
            if (w_sample == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CntLast) begin
                r_level <= w_sample;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_rise) begin
                r_press_count <= r_press_count + 8'd1;
            end
        end
    end

    assign bus.o_level       = r_level;
    assign bus.o_press       = r_press;
    assign bus.o_release     = r_release;
    assign bus.o_press_count = r_press_count;

`ifdef BUTTON_LONGPRESS_EN
    localparam int unsigned      HCntW    = $clog2(LONG_CYCLES + 1);
    localparam logic [HCntW-1:0] HCntLast = HCntW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDown, StHeld} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [HCntW-1:0] r_hcnt;
    logic [HCntW-1:0] w_hcnt_d;
    logic             r_long_press;
    logic             w_long_press_d;

    // Long-press next state; keyed off the same-cycle accept so long_press lands
    // exactly LONG_CYCLES edges after the press strobe edge.
    always_comb begin
        w_state_d      = r_state;
        w_hcnt_d       = r_hcnt;
        w_long_press_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_rise) begin
                    w_state_d = StDown;
                    w_hcnt_d  = '0;
                end
            end
            StDown: begin
                // Release beats a terminal count on the same edge.
                if (w_fall) begin
                    w_state_d = StIdle;
                end else if (r_hcnt == HCntLast) begin
                    w_long_press_d = 1'b1;
                    w_state_d      = StHeld;
                end else begin
                    w_hcnt_d = r_hcnt + 1'b1;
                end
            end
            StHeld: begin
                if (w_fall) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Long-press state, hold counter and strobe registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_hcnt       <= '0;
            r_long_press <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_hcnt       <= w_hcnt_d;
            r_long_press <= w_long_press_d;
        end
    end

    assign bus.o_long_press = r_long_press;
    assign bus.o_held       = (r_state == StHeld);
`else
    // LONG_CYCLES is kept only so instantiations stay identical across builds.
    logic w_unused_long;
    assign w_unused_long    = (LONG_CYCLES == 0);
    assign bus.o_long_press = 1'b0;
    assign bus.o_held       = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=0).
// Table of pin segments with hand-computed expected state, plus a strobe scoreboard.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 10;
`ifdef BUTTON_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    localparam int KPress = 0;
    localparam int KRel   = 1;
    localparam int KLong  = 2;

    typedef struct {
        int kind;
        int at;
        int cnt;
    } evt_t;

    typedef struct {
        bit btn;
        int n;
        bit ev;
        bit lp;
        bit lvl;
        int cnt;
        bit held;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    evt_t sb[$];
    vec_t tbl[$];

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .ACTIVE_LOW     (1'b0)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_evt(input int kind, input int at, input int cnt);
        evt_t e;
        e.kind = kind;
        e.at   = at;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    task automatic pop_evt(input int kind);
        evt_t e;
        if (sb.size() == 0) begin
            chk("unexpected_strobe", kind, -1);
            return;
        end
        e = sb.pop_front();
        chk("strobe_kind", kind, e.kind);
        chk("strobe_edge", cyc, e.at);
        if (kind == KPress) begin
            chk("count_at_press", int'(bus.o_press_count), e.cnt);
            chk("level_at_press", int'(bus.o_level), 1);
        end else if (kind == KRel) begin
            chk("level_at_release", int'(bus.o_level), 0);
            chk("held_at_release", int'(bus.o_held), 0);
        end else begin
            chk("held_at_long", int'(bus.o_held), 1);
        end
    endtask

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.o_press || bus.o_release) begin
            chk("press_release_exclusive", int'(bus.o_press & bus.o_release), 0);
        end
        if (bus.o_press) pop_evt(KPress);
        if (bus.o_release) pop_evt(KRel);
        if (bus.o_long_press) pop_evt(KLong);
    end

    // Drive the pin to v for n cycles starting at a negedge; ev/lp say whether a strobe
    // (and, when built, a long press) is expected from this segment.
    task automatic run_seg(input bit v, input int n, input bit ev, input bit lp);
        int e;
        e = cyc;
        bus.i_btn_raw = v;
        if (ev) begin
            if (v) begin
                exp_cnt = (exp_cnt + 1) % 256;
                push_evt(KPress, e + D + 2, exp_cnt);
                if (lp && LP_EN) push_evt(KLong, e + D + 2 + L, exp_cnt);
            end else begin
                push_evt(KRel, e + D + 2, exp_cnt);
            end
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"}, int'(bus.o_level), 0);
        chk({tag, "_press"}, int'(bus.o_press), 0);
        chk({tag, "_release"}, int'(bus.o_release), 0);
        chk({tag, "_count"}, int'(bus.o_press_count), 0);
        chk({tag, "_long"}, int'(bus.o_long_press), 0);
        chk({tag, "_held"}, int'(bus.o_held), 0);
    endtask

    // One-cycle synchronous reset pulse issued from a negedge.
    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        int r;
        bus.i_btn_raw = 1'b0;

        // btn, n, ev, lp, level, count, held (state at the end of the segment)
        tbl.push_back('{1'b1, 20, 1'b1, 1'b1, 1'b1, 1, 1'b1});
        tbl.push_back('{1'b0, 12, 1'b1, 1'b0, 1'b0, 1, 1'b0});
        for (int g = 0; g < 5; g++) begin
            tbl.push_back('{1'b1, 3, 1'b0, 1'b0, 1'b0, 1, 1'b0});
            tbl.push_back('{1'b0, 1, 1'b0, 1'b0, 1'b0, 1, 1'b0});
        end
        tbl.push_back('{1'b1, 9, 1'b1, 1'b0, 1'b1, 2, 1'b0});
        tbl.push_back('{1'b0, 12, 1'b1, 1'b0, 1'b0, 2, 1'b0});
        tbl.push_back('{1'b1, 10, 1'b1, 1'b0, 1'b1, 3, 1'b0});
        tbl.push_back('{1'b0, 12, 1'b1, 1'b0, 1'b0, 3, 1'b0});
        tbl.push_back('{1'b1, 11, 1'b1, 1'b1, 1'b1, 4, 1'b0});
        tbl.push_back('{1'b0, 12, 1'b1, 1'b0, 1'b0, 4, 1'b0});
        tbl.push_back('{1'b1, 4, 1'b1, 1'b0, 1'b0, 4, 1'b0});
        tbl.push_back('{1'b0, 12, 1'b1, 1'b0, 1'b0, 5, 1'b0});
        tbl.push_back('{1'b1, 3, 1'b0, 1'b0, 1'b0, 5, 1'b0});
        tbl.push_back('{1'b0, 8, 1'b0, 1'b0, 1'b0, 5, 1'b0});
        tbl.push_back('{1'b1, 36, 1'b1, 1'b1, 1'b1, 6, 1'b1});
        tbl.push_back('{1'b0, 12, 1'b1, 1'b0, 1'b0, 6, 1'b0});

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        foreach (tbl[i]) begin
            run_seg(tbl[i].btn, tbl[i].n, tbl[i].ev, tbl[i].lp);
            chk($sformatf("vec%0d_level", i), int'(bus.o_level), int'(tbl[i].lvl));
            chk($sformatf("vec%0d_count", i), int'(bus.o_press_count), tbl[i].cnt);
            chk($sformatf("vec%0d_held", i), int'(bus.o_held), int'(tbl[i].held && LP_EN));
        end

        // Reset while held: progress abandoned, press re-fires after a full debounce.
        run_seg(1'b1, 20, 1'b1, 1'b1);
        chk("pre_reset_held", int'(bus.o_held), int'(LP_EN));
        pulse_reset();
        r = cyc;
        chk_all_zero("mid_hold_reset");
        exp_cnt = 1;
        push_evt(KPress, r + D + 2, 1);
        if (LP_EN) push_evt(KLong, r + D + 2 + L, 1);
        repeat (20) @(negedge clk);
        chk("post_reset_held", int'(bus.o_held), int'(LP_EN));
        run_seg(1'b0, 12, 1'b1, 1'b0);
        chk("post_reset_count", int'(bus.o_press_count), 1);

        // Counter wrap: 257 clean presses from zero.
        pulse_reset();
        for (int k = 0; k < 257; k++) begin
            run_seg(1'b1, 6, 1'b1, 1'b0);
            run_seg(1'b0, 6, 1'b1, 1'b0);
        end
        chk("wrap_count", int'(bus.o_press_count), 1);
        chk("wrap_level", int'(bus.o_level), 0);

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw board push-button (`pwr_button`) before it reaches the LED animation logic. It synchronises the asynchronous pin, applies polarity, debounces, and produces a clean level, one-cycle press/release strobes, a wrapping press counter and an optional long-press strobe. It sits directly upstream of the LED animation block: `level` drives that block's button input, and the strobes are available to other control logic.

## Interface
- `DEBOUNCE_CYCLES`, 250000 — consecutive cycles the synchronised input must differ from `level` before `level` changes (10 ms at 25 MHz); legal range ≥1.
- `LONG_CYCLES`, 25000000 — cycles `level` must stay high after `press` before `long_press` fires (1 s at 25 MHz); legal range ≥1.
- `ACTIVE_LOW`, 0 — 1: a pressed button reads 0 on `btn_raw`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  1  asynchronous button pin.
- `level`  out  1  debounced pressed state (1 = pressed).
- `press`  out  1  one-cycle strobe when `level` rises.
- `release`  out  1  one-cycle strobe when `level` falls.
- `press_count`  out  8  number of presses, modulo 256.
- `long_press`  out  1  one-cycle strobe after a sustained press (see Configuration).
- `held`  out  1  high from `long_press` until release (see Configuration).

## Operation
- Synchroniser: two flops `s1`←`btn_raw`, `s2`←`s1`; `sample = s2 XOR ACTIVE_LOW`. On reset both flops load `ACTIVE_LOW`, so `sample` = 0.
- Debounce counter `cnt`, width clog2(DEBOUNCE_CYCLES+1):
  - `sample == level`: `cnt` ← 0.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `level` ← `sample`, `cnt` ← 0, and `press` (rising) or `release` (falling) asserts for exactly that one cycle.
  - Otherwise `cnt` ← `cnt`+1.
- Glitches: any single cycle with `sample == level` restarts the count. Pulses shorter than `DEBOUNCE_CYCLES` never change `level`.
- `press_count` increments on every `press`. It wraps from 255 to 0 with no saturation.
- `press` and `release` are never asserted together. Once a change has been accepted, the next opposite change needs another full `DEBOUNCE_CYCLES`.
- Long-press FSM (compiled in only) has states IDLE, DOWN and HELD:
  - IDLE→DOWN on `press`; `hcnt` ← 0.
  - In DOWN, if `hcnt == LONG_CYCLES-1`, assert `long_press` for one cycle and go to HELD. Otherwise `hcnt` increments.
  - DOWN or HELD → IDLE on `release`. Release wins over a terminal count on the same edge: no `long_press` is issued.
  - `held` = (state == HELD).
- Reset values: `level`, `press`, `release`, `long_press`, `held` = 0; `press_count` = 0; `cnt` = `hcnt` = 0; state IDLE.
- Reset mid-debounce or mid-hold abandons all progress. A button still held after reset is reported as a new `press` after a full debounce.

## Timing
- Edge 1 is the first rising edge that captures a new `btn_raw` value into `s1`, provided the value stays stable.
  - `level` and `press` (or `release`) update on edge `DEBOUNCE_CYCLES`+2.
  - `press_count` updates on that same edge.
- `long_press` rises exactly `LONG_CYCLES` edges after the edge on which `press` rose, provided no `release` occurs in between. `held` rises on the same edge.
- All outputs are registered. There is no combinational path from `btn_raw` to any output.
- Throughput: no handshake. Strobes are single-cycle, and consumers must sample them every cycle.

## Configuration
- `BUTTON_LONGPRESS_EN` defined: the IDLE/DOWN/HELD FSM and `hcnt` are built, and `long_press` and `held` behave as above.
- Not defined: the FSM and `hcnt` are omitted, and `long_press` and `held` are tied to 0. The ports remain so instantiations are unchanged, and `LONG_CYCLES` is ignored.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=10, `ACTIVE_LOW`=0, with `BUTTON_LONGPRESS_EN` defined unless noted.

1. Clean press: `btn_raw` 0→1 before edge 1 and held → `level` = `press` = 1 on edge 6; `press` = 0 on edge 7; `press_count` = 1.
2. Glitch rejection: `btn_raw` high for 3 cycles, low for 1, repeated 5 times → `level` stays 0, no strobes, `press_count` = 0.
3. Long press: hold 30 cycles after `press` → `long_press` is a single pulse 10 edges after `press`; `held` is 1 until the `release` edge, then 0.
4. Short press: release sampled so `release` lands 9 edges after `press`, i.e. before the terminal count → no `long_press`, `held` never 1, FSM back in IDLE.
5. Counter wrap: 257 clean presses → `press_count` reads 1; each press produces exactly one `press` and one `release`.
6. Reset and macro checks:
   - `rst` for 1 cycle while the button is held in HELD → all outputs 0 the next cycle; `press` re-fires 6 edges later.
   - Rebuilt without the macro, scenario 3 shows `long_press` = `held` = 0 throughout.
